// File: rtl/soc_io_pkg.sv
// soc_io_pkg: shared constants and TX state encoding for the IO responder
package soc_io_pkg;
    localparam int IO_BIT       = 22;
    localparam int WSEL_LSB     = 2;
    localparam int SEL_LEDS     = 0;
    localparam int SEL_DAT      = 1;
    localparam int SEL_CNTL     = 2;
    localparam int CNTL_BUSY    = 9;
    localparam int CNTL_OVERRUN = 8;
    localparam int FRAME_BITS   = 10;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 serialiser with per-bit baud counter and registered txd
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       txd
);
    import soc_io_pkg::*;
    localparam int CW = CLKS_PER_BIT < 2 ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);
    tx_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic txd_q, txd_d, tick;
    assign tick = cnt_q == LAST;
    assign busy = state_q != TX_IDLE;
    assign txd  = txd_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == TX_IDLE) ? cnt_q : tick ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        case (state_q)
            TX_IDLE: if (start) begin
                state_d = TX_START;
                cnt_d   = '0;
                sh_d    = data;
                txd_d   = 1'b0;
            end
            TX_START: if (tick) begin
                state_d = TX_DATA;
                bit_d   = '0;
                txd_d   = sh_q[0];
                sh_d    = sh_q >> 1;
            end
            TX_DATA: if (tick) begin
                if (bit_q == LAST_BIT) begin
                    state_d = TX_STOP;
                    txd_d   = 1'b1;
                end else begin
                    bit_d = bit_q + 3'd1;
                    txd_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                end
            end
            TX_STOP: if (tick) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
        end
    end
endmodule

// File: rtl/soc_io_responder.sv
// soc_io_responder: IO page decode with LED register, UART TX and registered read data
module soc_io_responder #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200,
    parameter int LED_WIDTH   = 5,
    parameter int IO_BIT      = soc_io_pkg::IO_BIT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wmask,
    input  logic                 mem_rstrb,
    output logic [31:0]          io_rdata,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 TXD
);
    import soc_io_pkg::*;
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("soc_io_responder: CLK_FREQ_HZ/BAUD must be at least 2");
    end
    logic io, wr, rd, sel_leds, sel_dat, sel_cntl, busy, accept, ovr_set;
    logic ovr_q, ovr_d, unused_bits;
    logic [LED_WIDTH-1:0] leds_q, leds_d;
    logic [31:0] rdata_q, rdata_d, cntl;
    assign io          = mem_addr[IO_BIT];
    assign sel_leds    = mem_addr[WSEL_LSB + SEL_LEDS];
    assign sel_dat     = mem_addr[WSEL_LSB + SEL_DAT];
    assign sel_cntl    = mem_addr[WSEL_LSB + SEL_CNTL];
    assign wr          = io && (mem_wmask != 4'b0);
    assign rd          = io && mem_rstrb;
    assign unused_bits = ^{mem_addr, mem_wdata};
    always_comb begin
        accept  = wr && sel_dat && mem_wmask[0] && !busy;
        ovr_set = wr && sel_dat && mem_wmask[0] && busy;
        leds_d  = (wr && sel_leds && mem_wmask[0]) ? mem_wdata[LED_WIDTH-1:0] : leds_q;
        // a dropped byte in the same cycle as a status read keeps the flag set
        ovr_d   = ovr_set ? 1'b1 : (rd && sel_cntl) ? 1'b0 : ovr_q;
        cntl    = '0;
        cntl[CNTL_BUSY]    = busy;
        cntl[CNTL_OVERRUN] = ovr_q;
        rdata_d = !mem_rstrb ? rdata_q : !io ? '0 :
                  ((sel_leds ? 32'(leds_q) : '0) | (sel_cntl ? cntl : '0));
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            leds_q  <= '0;
            ovr_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            leds_q  <= leds_d;
            ovr_q   <= ovr_d;
            rdata_q <= rdata_d;
        end
    end
    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk    (clk),
        .resetn (resetn),
        .start  (accept),
        .data   (mem_wdata[7:0]),
        .busy   (busy),
        .txd    (TXD)
    );
    assign leds     = leds_q;
    assign io_rdata = rdata_q;
endmodule

// File: tb/tb_soc_io_responder.sv
// tb_soc_io_responder: directed vectors for LEDS, UART frames, overrun and reset
module tb_soc_io_responder;
    logic        clk = 1'b0, resetn = 1'b1;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] io_rdata;
    logic [4:0]  leds;
    logic        TXD;
    int n_vec = 0, n_bad = 0;
    soc_io_responder #(.CLK_FREQ_HZ(1000000), .BAUD(100000)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .io_rdata  (io_rdata),
        .leds      (leds),
        .TXD       (TXD)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic r);
        @(negedge clk);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        mem_rstrb = r;
        @(posedge clk);
        #1;
        mem_wmask = '0;
        mem_rstrb = 1'b0;
    endtask
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int i;
        i = k / 10;
        return (i == 0) ? 1'b0 : (i >= 9) ? 1'b1 : b[i-1];
    endfunction
    initial begin
        #1 resetn = 1'b0;
        #10;
        check("rst_rdata", io_rdata, 32'h0);
        check("rst_leds", {27'b0, leds}, 32'h0);
        check("rst_txd", {31'b0, TXD}, 32'h1);
        @(negedge clk) resetn = 1'b1;
        bus(32'h0040_0004, 32'h1F, 4'b0001, 1'b0);
        check("leds_wr", {27'b0, leds}, 32'h1F);
        bus(32'h0040_0004, 32'h0, 4'b0000, 1'b1);
        check("leds_rd", io_rdata, 32'h1F);
        repeat (3) @(posedge clk);
        #1 check("rdata_hold", io_rdata, 32'h1F);
        bus(32'h0040_0004, 32'h0, 4'b0000, 1'b0);
        check("wmask0", {27'b0, leds}, 32'h1F);
        bus(32'h0000_0004, 32'h0, 4'b0001, 1'b0);
        check("nonio_wr", {27'b0, leds}, 32'h1F);
        bus(32'h0000_0010, 32'h0, 4'b0000, 1'b1);
        check("nonio_rd", io_rdata, 32'h0);
        bus(32'h0040_0008, 32'h55, 4'b0001, 1'b0);
        check("start_bit", {31'b0, TXD}, 32'h0);
        for (int k = 1; k <= 140; k++) begin
            @(negedge clk);
            mem_addr  = '0;
            mem_wdata = '0;
            mem_wmask = '0;
            mem_rstrb = 1'b0;
            if (k == 20) begin
                mem_addr  = 32'h0040_0008;
                mem_wdata = 32'hA5;
                mem_wmask = 4'b0001;
            end
            if (k == 25 || k == 27 || k == 99 || k == 103) begin
                mem_addr  = 32'h0040_0010;
                mem_rstrb = 1'b1;
            end
            if (k == 101) begin
                mem_addr  = 32'h0040_0018;
                mem_wdata = 32'h33;
                mem_wmask = 4'b0001;
                mem_rstrb = 1'b1;
            end
            @(posedge clk);
            #1;
            if (k < 100 && k % 10 == 5) check("txd_55", {31'b0, TXD}, {31'b0, frame_bit(8'h55, k)});
            if (k > 101 && (k - 101) % 10 == 5) check("txd_33", {31'b0, TXD}, {31'b0, frame_bit(8'h33, k - 101)});
            if (k == 25)  check("cntl_ovr", io_rdata, 32'h300);
            if (k == 27)  check("cntl_clr", io_rdata, 32'h200);
            if (k == 99)  check("cntl_stop", io_rdata, 32'h200);
            if (k == 100) check("gap_idle", {31'b0, TXD}, 32'h1);
            if (k == 101) begin
                check("rdwr_pre", io_rdata, 32'h0);
                check("b2b_start", {31'b0, TXD}, 32'h0);
            end
            if (k == 103) check("cntl_busy2", io_rdata, 32'h200);
        end
        #2 resetn = 1'b0;
        #1;
        check("midrst_txd", {31'b0, TXD}, 32'h1);
        check("midrst_leds", {27'b0, leds}, 32'h0);
        check("midrst_rdata", io_rdata, 32'h0);
        @(negedge clk) resetn = 1'b1;
        bus(32'h0040_0010, 32'h0, 4'b0000, 1'b1);
        check("post_rst_cntl", io_rdata, 32'h0);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (k % 10 == 5) check("no_resume", {31'b0, TXD}, 32'h1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
